// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl : MEM stage of the pipeline.
// Consumes the EX/MEM register, runs loads/stores over a req/ack data-memory
// port, stalls upstream while an access is open, resolves branch/jump
// redirects and drives the MEM/WB register toward write-back.
//
// Ports
//   CLK, RST                 clock (posedge) / async active-high reset
//   Valid4 .. MemtoReg4      EX/MEM values and controls
//   Branch_addr1, Jump_addr1 redirect targets
//   mem_req/we/addr/wdata    data-memory request (registered, held until done)
//   mem_ack, mem_rdata       data-memory completion pulse and load data
//   Stall                    hold PC, IF/ID, ID/EX, EX/MEM
//   Redirect, Redirect_addr  next-PC override
//   RegWrite5 .. ReadData5   MEM/WB register
//   Mem_err                  sticky access-timeout flag
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Valid4,
  input  logic [DW-1:0] ALUResult4,
  input  logic [DW-1:0] Wdata4,
  input  logic [RW-1:0] Wreg_addr4,
  input  logic [DW-1:0] Branch_addr1,
  input  logic [DW-1:0] Jump_addr1,
  input  logic          PCSrc4,
  input  logic          JtoPC4,
  input  logic          Branch4,
  input  logic          RegWrite4,
  input  logic          MemWrite4,
  input  logic          MemRead4,
  input  logic          MemtoReg4,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          Stall,
  output logic          Redirect,
  output logic [DW-1:0] Redirect_addr,
  output logic          RegWrite5,
  output logic          MemtoReg5,
  output logic [RW-1:0] Wreg_addr5,
  output logic [DW-1:0] ALUResult5,
  output logic [DW-1:0] ReadData5,
  output logic          Mem_err
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rw5_q, rw5_d;
  logic          m2r5_q, m2r5_d;
  logic [RW-1:0] wa5_q, wa5_d;
  logic [DW-1:0] alu5_q, alu5_d;
  logic [DW-1:0] rd5_q, rd5_d;
  logic          err_q, err_d;
  logic          memop_s;

  assign memop_s = Valid4 & (MemRead4 | MemWrite4);

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw5_q   <= 1'b0;
      m2r5_q  <= 1'b0;
      wa5_q   <= '0;
      alu5_q  <= '0;
      rd5_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw5_q   <= rw5_d;
      m2r5_q  <= m2r5_d;
      wa5_q   <= wa5_d;
      alu5_q  <= alu5_d;
      rd5_q   <= rd5_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic of the access FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw5_d   = rw5_q;
    m2r5_d  = m2r5_q;
    wa5_d   = wa5_q;
    alu5_d  = alu5_q;
    rd5_d   = rd5_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (memop_s) begin
          // Launch the access; store wins when both read and write are set.
          state_d = S_BUSY;
          req_d   = 1'b1;
          we_d    = MemWrite4;
          addr_d  = ALUResult4;
          wdata_d = Wdata4;
          cnt_d   = '0;
          rw5_d   = 1'b0;
          m2r5_d  = 1'b0;
          wa5_d   = '0;
          alu5_d  = '0;
          rd5_d   = '0;
        end else begin
          rw5_d  = Valid4 & RegWrite4;
          m2r5_d = MemtoReg4;
          wa5_d  = Wreg_addr4;
          alu5_d = ALUResult4;
          rd5_d  = '0;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          // EX/MEM is frozen by Stall, so it still holds the accessing instruction.
          state_d = S_DONE;
          req_d   = 1'b0;
          rw5_d   = Valid4 & RegWrite4;
          m2r5_d  = MemtoReg4;
          wa5_d   = Wreg_addr4;
          alu5_d  = ALUResult4;
          rd5_d   = (MemRead4 & ~MemWrite4) ? mem_rdata : '0;
        end else if (cnt_q == CNT_MAX) begin
          // Give up: the instruction is dropped and the error latched.
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          rw5_d   = 1'b0;
          m2r5_d  = 1'b0;
          wa5_d   = '0;
          alu5_d  = '0;
          rd5_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          rw5_d = 1'b0;
        end
      end
      S_DONE: begin
        // Release cycle: EX/MEM advances on this edge, MEM/WB takes a bubble.
        state_d = S_IDLE;
        rw5_d   = 1'b0;
        m2r5_d  = 1'b0;
        wa5_d   = '0;
        alu5_d  = '0;
        rd5_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Stall and redirect are decoded from the current state and EX/MEM contents.
  always_comb begin
    Stall         = 1'b0;
    Redirect      = 1'b0;
    Redirect_addr = '0;
    if (RST) begin
      Stall = 1'b0;
    end else if (state_q == S_BUSY) begin
      Stall = 1'b1;
    end else if (state_q == S_IDLE) begin
      Stall = memop_s;
      if (Valid4 && JtoPC4) begin
        Redirect      = 1'b1;
        Redirect_addr = Jump_addr1;
      end else if (Valid4 && PCSrc4 && Branch4) begin
        Redirect      = 1'b1;
        Redirect_addr = Branch_addr1;
      end else begin
        Redirect = 1'b0;
      end
    end else begin
      Stall = 1'b0;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign RegWrite5  = rw5_q;
  assign MemtoReg5  = m2r5_q;
  assign Wreg_addr5 = wa5_q;
  assign ALUResult5 = alu5_q;
  assign ReadData5  = rd5_q;
  assign Mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl : self-checking bench for mem_stage_ctrl.
// Each instruction is applied to EX/MEM and held while Stall is high, as an
// upstream pipeline would. Expected behaviour per instruction is derived from
// its fields and the memory ack latency chosen for it.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          Valid4, PCSrc4, JtoPC4, Branch4, RegWrite4, MemWrite4, MemRead4, MemtoReg4;
  logic [DW-1:0] ALUResult4, Wdata4, Branch_addr1, Jump_addr1;
  logic [RW-1:0] Wreg_addr4;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;
  logic          Stall, Redirect;
  logic [DW-1:0] Redirect_addr;
  logic          RegWrite5, MemtoReg5, Mem_err;
  logic [RW-1:0] Wreg_addr5;
  logic [DW-1:0] ALUResult5, ReadData5;

  int tests = 0;
  int fails = 0;
  logic exp_err = 1'b0;

  typedef struct {
    logic        v, rw, m2r, mw, mr, pcs, jt, br;
    logic [4:0]  wa;
    logic [31:0] alu, wd, ba, ja, rdata;
    int          ack_lat;
  } instr_t;

  mem_stage_ctrl #(.DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .Valid4(Valid4), .ALUResult4(ALUResult4), .Wdata4(Wdata4),
    .Wreg_addr4(Wreg_addr4), .Branch_addr1(Branch_addr1), .Jump_addr1(Jump_addr1),
    .PCSrc4(PCSrc4), .JtoPC4(JtoPC4), .Branch4(Branch4), .RegWrite4(RegWrite4),
    .MemWrite4(MemWrite4), .MemRead4(MemRead4), .MemtoReg4(MemtoReg4),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Stall(Stall), .Redirect(Redirect),
    .Redirect_addr(Redirect_addr), .RegWrite5(RegWrite5), .MemtoReg5(MemtoReg5),
    .Wreg_addr5(Wreg_addr5), .ALUResult5(ALUResult5), .ReadData5(ReadData5), .Mem_err(Mem_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input instr_t t);
    Valid4 = t.v; RegWrite4 = t.rw; MemtoReg4 = t.m2r; MemWrite4 = t.mw; MemRead4 = t.mr;
    PCSrc4 = t.pcs; JtoPC4 = t.jt; Branch4 = t.br; Wreg_addr4 = t.wa; ALUResult4 = t.alu;
    Wdata4 = t.wd; Branch_addr1 = t.ba; Jump_addr1 = t.ja;
  endtask

  // Runs one instruction starting just after a negedge; returns just after a
  // negedge at which the next instruction may be applied.
  task automatic run_instr(input instr_t t);
    logic        memop, r, acked;
    logic [31:0] ra;
    apply(t);
    mem_ack = 1'b0;
    memop = t.v & (t.mr | t.mw);
    if (t.v && t.jt) begin
      r = 1'b1; ra = t.ja;
    end else if (t.v && t.pcs && t.br) begin
      r = 1'b1; ra = t.ba;
    end else begin
      r = 1'b0; ra = 32'h0;
    end
    if (!memop) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
    #1;
    chk("redirect", Redirect, r);
    chk("redirect_addr", Redirect_addr, ra);
    chk("stall_issue", Stall, memop);
    if (!memop) begin
      @(negedge CLK);
      mem_ack = 1'b0;
      chk("rw5", RegWrite5, t.v & t.rw);
      if (t.v) begin
        chk("wa5", Wreg_addr5, t.wa);
        chk("alu5", ALUResult5, t.alu);
        chk("m2r5", MemtoReg5, t.m2r);
      end
      chk("req_idle", mem_req, 1'b0);
    end else begin
      acked = 1'b0;
      for (int k = 1; k <= TO; k++) begin
        @(negedge CLK);
        mem_ack = 1'b0;
        chk("busy_req", mem_req, 1'b1);
        chk("busy_addr", mem_addr, t.alu);
        chk("busy_we", mem_we, t.mw);
        chk("busy_wdata", mem_wdata, t.wd);
        chk("busy_stall", Stall, 1'b1);
        chk("busy_redirect", Redirect, 1'b0);
        chk("busy_rw5", RegWrite5, 1'b0);
        if (k == t.ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = t.rdata;
          acked     = 1'b1;
        end
        if (acked) break;
      end
      @(negedge CLK);
      // Stray ack while DONE must be ignored.
      mem_ack = 1'($urandom_range(0, 1));
      if (!acked) exp_err = 1'b1;
      chk("done_req", mem_req, 1'b0);
      chk("done_stall", Stall, 1'b0);
      chk("done_redirect", Redirect, 1'b0);
      chk("mem_err", Mem_err, exp_err);
      if (acked) begin
        chk("wb_rw5", RegWrite5, t.rw);
        chk("wb_m2r5", MemtoReg5, t.m2r);
        chk("wb_wa5", Wreg_addr5, t.wa);
        chk("wb_alu5", ALUResult5, t.alu);
        chk("wb_rd5", ReadData5, (t.mr && !t.mw) ? t.rdata : 32'h0);
      end else begin
        chk("drop_rw5", RegWrite5, 1'b0);
      end
      @(negedge CLK);
      mem_ack = 1'b0;
      chk("bubble_rw5", RegWrite5, 1'b0);
      chk("bubble_req", mem_req, 1'b0);
    end
  endtask

  initial begin
    instr_t t;
    RST = 1'b1;
    t = '{default: 0};
    apply(t);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge CLK); @(negedge CLK);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", Stall, 1'b0);
    chk("rst_rw5", RegWrite5, 1'b0);
    chk("rst_alu5", ALUResult5, 32'h0);
    chk("rst_err", Mem_err, 1'b0);
    RST = 1'b0;
    @(negedge CLK);

    // ALU op
    t = '{default: 0}; t.v = 1'b1; t.rw = 1'b1; t.wa = 5'd5; t.alu = 32'h10;
    run_instr(t);
    // Load, ack after 3 BUSY cycles
    t = '{default: 0}; t.v = 1'b1; t.rw = 1'b1; t.mr = 1'b1; t.m2r = 1'b1; t.wa = 5'd7;
    t.alu = 32'h40; t.rdata = 32'hDEADBEEF; t.ack_lat = 3;
    run_instr(t);
    // Store
    t = '{default: 0}; t.v = 1'b1; t.mw = 1'b1; t.alu = 32'h80; t.wd = 32'h1234; t.ack_lat = 5;
    run_instr(t);
    // Ack in the very last BUSY cycle wins over timeout
    t = '{default: 0}; t.v = 1'b1; t.rw = 1'b1; t.mr = 1'b1; t.wa = 5'd3; t.alu = 32'h44;
    t.rdata = 32'hCAFEF00D; t.ack_lat = TO;
    run_instr(t);
    // Timeout
    t = '{default: 0}; t.v = 1'b1; t.rw = 1'b1; t.mr = 1'b1; t.wa = 5'd9; t.alu = 32'h48;
    t.ack_lat = TO + 4;
    run_instr(t);
    // Jump has priority over branch; then invalid jump
    t = '{default: 0}; t.v = 1'b1; t.jt = 1'b1; t.pcs = 1'b1; t.br = 1'b1;
    t.ja = 32'h100; t.ba = 32'h200;
    run_instr(t);
    t.v = 1'b0;
    run_instr(t);
    // Read and write both set: store wins
    t = '{default: 0}; t.v = 1'b1; t.mr = 1'b1; t.mw = 1'b1; t.alu = 32'hC0; t.wd = 32'h55;
    t.rdata = 32'hFFFF0000; t.ack_lat = 2;
    run_instr(t);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      int kind;
      t = '{default: 0};
      kind      = $urandom_range(0, 4);
      t.v       = ($urandom_range(0, 7) != 0);
      t.rw      = 1'($urandom_range(0, 1));
      t.m2r     = 1'($urandom_range(0, 1));
      t.pcs     = 1'($urandom_range(0, 1));
      t.br      = 1'($urandom_range(0, 1));
      t.jt      = ($urandom_range(0, 3) == 0);
      t.wa      = 5'($urandom);
      t.alu     = $urandom; t.wd = $urandom; t.ba = $urandom; t.ja = $urandom;
      t.rdata   = $urandom;
      t.mr      = (kind == 2) || (kind == 4);
      t.mw      = (kind == 3) || (kind == 4 && $urandom_range(0, 3) == 0);
      t.ack_lat = $urandom_range(1, TO + 2);
      run_instr(t);
    end

    // Reset in the middle of an access
    t = '{default: 0}; t.v = 1'b1; t.rw = 1'b1; t.mr = 1'b1; t.alu = 32'h60; t.wa = 5'd4;
    apply(t);
    @(negedge CLK); @(negedge CLK);
    chk("pre_rst_req", mem_req, 1'b1);
    RST = 1'b1;
    #1;
    chk("rst_busy_req", mem_req, 1'b0);
    chk("rst_busy_stall", Stall, 1'b0);
    chk("rst_busy_rw5", RegWrite5, 1'b0);
    chk("rst_busy_rd5", ReadData5, 32'h0);
    chk("rst_busy_err", Mem_err, 1'b0);
    exp_err = 1'b0;
    @(negedge CLK);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    t = '{default: 0};
    apply(t);
    RST = 1'b0;
    @(negedge CLK);
    mem_ack = 1'b0;
    chk("post_rst_req", mem_req, 1'b0);
    chk("post_rst_stall", Stall, 1'b0);
    chk("post_rst_rd5", ReadData5, 32'h0);
    chk("post_rst_err", Mem_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
